testdrive_axi4_lite_slave_mem: RTL and testbench
================================================

# testdrive_axi4_lite_slave_mem

Parametrised, synthesizable AXI4-Lite slave memory model used as a bus target in TestDrive system simulations where no DPI host model is wanted. It stores data in an internal word array, accepts write address and write data independently, and returns read data after a programmable fixed latency. It supports multiple outstanding reads and reports out-of-range accesses with SLVERR. Data width, depth, latency and outstanding depth are all configurable.

## Interface
- C_ADDR_WIDTH, 20, byte address width (≥ C_MEM_DEPTH_LOG2 + log2(C_DATA_WIDTH/8)).
- C_DATA_WIDTH, 32, data width; 32 or 64 only.
- C_BASE_ADDR, 0, byte address of word 0; aligned to memory size.
- C_MEM_DEPTH_LOG2, 10, log2 of word count.
- C_READ_LATENCY, 2, AR handshake to earliest RVALID in cycles; 1..15.
- C_OUTSTANDING, 4, maximum accepted-but-unreturned reads; power of 2, ≥ 1.
- CLK  in  1  clock, all logic on the rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- AWADDR  in  C_ADDR_WIDTH  write byte address.
- AWVALID / AWREADY  in / out  1  write address handshake.
- WDATA  in  C_DATA_WIDTH  write data.
- WSTRB  in  C_DATA_WIDTH/8  byte enables.
- WVALID / WREADY  in / out  1  write data handshake.
- BRESP  out  2  2'b00 OKAY, 2'b10 SLVERR.
- BVALID / BREADY  out / in  1  write response handshake.
- ARADDR  in  C_ADDR_WIDTH  read byte address.
- ARVALID / ARREADY  in / out  1  read address handshake.
- RDATA  out  C_DATA_WIDTH  read data.
- RRESP  out  2  2'b00 OKAY, 2'b10 SLVERR.
- RVALID / RREADY  out / in  1  read data handshake.

## Operation
- Reset: all outputs are 0 while nRST=0. READY outputs go high at the first rising edge after deassertion. All buffers, pipelines, FIFOs and counters are cleared. Memory contents are not reset and are retained across reset.
- Reset mid-operation drops every in-flight transaction. No BVALID or RVALID for those transactions appears after reset.
- Address decode:
  - word index = (addr − C_BASE_ADDR) >> log2(C_DATA_WIDTH/8); low byte-offset bits are ignored.
  - In range when C_BASE_ADDR ≤ addr < C_BASE_ADDR + (2^C_MEM_DEPTH_LOG2 × bytes).
- Write path:
  - One-entry AW buffer and one-entry W buffer. AWREADY = !aw_full. WREADY = !w_full.
  - AW and W may arrive in either order or in the same cycle.
  - Commit condition: aw_full && w_full && (!BVALID || BREADY).
  - On commit, in range: bytes with WSTRB[i]=1 are written; others keep their value. BRESP=OKAY.
  - On commit, out of range: memory is not modified. BRESP=SLVERR.
  - Commit clears both buffers and sets BVALID. BVALID and BRESP hold until BREADY=1.
  - WSTRB=0 in range is a no-op write with OKAY.
- Read path:
  - ARREADY = (credit < C_OUTSTANDING). credit increments on an AR handshake and decrements on an R handshake; both in one cycle leaves it unchanged.
  - Memory is sampled at the AR handshake edge. The entry then passes through a C_READ_LATENCY-stage delay into a C_OUTSTANDING-deep return FIFO. Credit guarantees the FIFO never overflows.
  - RVALID = FIFO not empty. RDATA and RRESP come from the FIFO head, in order.
  - Out-of-range read returns RDATA=0 with SLVERR.
- Ordering:
  - A read accepted on the same edge as a write commit to the same word returns the old data.
  - A read accepted any later returns the new data.

## Timing
- Write: if the last of AW/W handshakes at edge N with B idle, commit and BVALID=1 occur at edge N+1. BVALID drops at the edge after BREADY=1.
- Write throughput: one write per 2 cycles, because READY is low in the commit cycle.
- Stalled write: with BVALID=1 and BREADY=0, both buffers may fill. AWREADY and WREADY then stay 0 until the B handshake. Commit happens in the same cycle as that B handshake, so BVALID stays high for the next response.
- Read: AR handshake at edge N gives RVALID=1 no earlier than edge N+C_READ_LATENCY. With RREADY held at 1, back-to-back ARs return back-to-back Rs.
- Read throughput with RREADY=1: one read per cycle when C_OUTSTANDING ≥ C_READ_LATENCY+1. Otherwise ARREADY stalls.
- Credit full: ARREADY=0 in the cycle credit==C_OUTSTANDING. An R handshake that cycle raises ARREADY at the next edge.
- AXI stability: RDATA/RRESP and BRESP do not change while VALID=1 and READY=0.

## Test plan
- Reset then write: AW 0x10 with W 0xA5A5_1234 and WSTRB 4'hF in the same cycle. BVALID must follow 1 cycle later with OKAY. A read of 0x10 must return 0xA5A5_1234, OKAY, exactly C_READ_LATENCY cycles after AR.
- Byte strobes and ordering: W first (0xFFFF_FFFF, WSTRB 4'b0101), AW to 0x10 three cycles later. A read must return 0xA5FF_12FF.
- Out of range: write to C_BASE_ADDR + 4×1024 (32-bit words, depth 1024) must give SLVERR. A read of that address must give RDATA 0 with SLVERR, and memory word 1023 must be unchanged.
- Outstanding reads (C_OUTSTANDING=4): issue 6 back-to-back ARs with RREADY=0. ARREADY must drop after the 4th. Raising RREADY must return data in order, with ARREADY re-asserting one cycle after the first R handshake.
- Backpressure: hold BREADY=0 and issue two writes. Exactly one BVALID must stay held, and both READYs must stay 0 until BREADY. Then the second response must follow with no BVALID gap.
- Reset mid-read: assert nRST with 3 reads in flight. All outputs must read 0 during reset. After release, no RVALID appears and ARREADY=1 on the first edge.

Source files
------------

// File: rtl/testdrive_axi4_lite_slave_mem.sv
// AXI4-Lite slave memory: independent AW/W buffering, byte-strobed writes, and
// fixed-latency pipelined reads with in-order return and SLVERR on out-of-range.
module testdrive_axi4_lite_slave_mem #(
  parameter int          C_ADDR_WIDTH     = 20,
  parameter int          C_DATA_WIDTH     = 32,
  parameter logic [63:0] C_BASE_ADDR      = 64'h0,
  parameter int          C_MEM_DEPTH_LOG2 = 10,
  parameter int          C_READ_LATENCY   = 2,
  parameter int          C_OUTSTANDING    = 4
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic [C_ADDR_WIDTH-1:0]   AWADDR,
  input  logic                      AWVALID,
  output logic                      AWREADY,
  input  logic [C_DATA_WIDTH-1:0]   WDATA,
  input  logic [C_DATA_WIDTH/8-1:0] WSTRB,
  input  logic                      WVALID,
  output logic                      WREADY,
  output logic [1:0]                BRESP,
  output logic                      BVALID,
  input  logic                      BREADY,
  input  logic [C_ADDR_WIDTH-1:0]   ARADDR,
  input  logic                      ARVALID,
  output logic                      ARREADY,
  output logic [C_DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]                RRESP,
  output logic                      RVALID,
  input  logic                      RREADY
);

  localparam int STRB_W    = C_DATA_WIDTH / 8;
  localparam int BYTE_LOG2 = $clog2(STRB_W);
  localparam int MEM_LOG2  = C_MEM_DEPTH_LOG2 + BYTE_LOG2;
  localparam int DEPTH     = 1 << C_MEM_DEPTH_LOG2;
  localparam int CNT_W     = $clog2(C_OUTSTANDING + 1);
  localparam int IDX_W     = (C_OUTSTANDING > 1) ? $clog2(C_OUTSTANDING) : 1;
  localparam logic [C_ADDR_WIDTH-1:0] BASE = C_BASE_ADDR[C_ADDR_WIDTH-1:0];
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                      readyEn_q;
  logic                      awFull_q;
  logic [C_ADDR_WIDTH-1:0]   awAddr_q;
  logic                      wFull_q;
  logic [C_DATA_WIDTH-1:0]   wData_q;
  logic [STRB_W-1:0]         wStrb_q;
  logic                      bValid_q;
  logic [1:0]                bResp_q;

  logic                      awHs, wHs, arHs, rHs, commit;
  logic [C_ADDR_WIDTH-1:0]   awOffset, arOffset;
  logic                      awInRange, arInRange;
  logic [C_MEM_DEPTH_LOG2-1:0] awIdx, arIdx;

  logic [C_DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic [C_READ_LATENCY-1:0] pipeValid_q;
  logic [C_DATA_WIDTH-1:0]   pipeData_q [C_READ_LATENCY];
  logic [1:0]                pipeResp_q [C_READ_LATENCY];

  logic [C_DATA_WIDTH-1:0]   fifoData_q [C_OUTSTANDING];
  logic [1:0]                fifoResp_q [C_OUTSTANDING];
  logic [IDX_W-1:0]          wrIdx_q, rdIdx_q;
  logic [CNT_W-1:0]          count_q, credit_q;
  logic                      push, rValid;

  function automatic logic [IDX_W-1:0] nextIdx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(C_OUTSTANDING - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

  // Offsets are computed modulo the address width; the >= BASE term rejects wrap-around.
  assign awOffset  = awAddr_q - BASE;
  assign arOffset  = ARADDR - BASE;
  assign awInRange = (awAddr_q >= BASE) && ((awOffset >> MEM_LOG2) == '0);
  assign arInRange = (ARADDR >= BASE) && ((arOffset >> MEM_LOG2) == '0);
  assign awIdx     = awOffset[BYTE_LOG2 +: C_MEM_DEPTH_LOG2];
  assign arIdx     = arOffset[BYTE_LOG2 +: C_MEM_DEPTH_LOG2];

  assign AWREADY = readyEn_q && !awFull_q;
  assign WREADY  = readyEn_q && !wFull_q;
  assign ARREADY = readyEn_q && (credit_q < CNT_W'(C_OUTSTANDING));
  assign BVALID  = bValid_q;
  assign BRESP   = bResp_q;

  assign awHs   = AWVALID && AWREADY;
  assign wHs    = WVALID && WREADY;
  assign arHs   = ARVALID && ARREADY;
  assign rValid = (count_q != '0);
  assign rHs    = rValid && RREADY;
  assign commit = awFull_q && wFull_q && (!bValid_q || BREADY);
  assign push   = pipeValid_q[C_READ_LATENCY-1];

  assign RVALID = rValid;
  assign RDATA  = rValid ? fifoData_q[rdIdx_q] : '0;
  assign RRESP  = rValid ? fifoResp_q[rdIdx_q] : RESP_OKAY;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      readyEn_q <= 1'b0;
      awFull_q  <= 1'b0;
      wFull_q   <= 1'b0;
      bValid_q  <= 1'b0;
      bResp_q   <= RESP_OKAY;
    end else begin
      readyEn_q <= 1'b1;
      if (commit)    awFull_q <= 1'b0;
      else if (awHs) awFull_q <= 1'b1;
      if (commit)    wFull_q  <= 1'b0;
      else if (wHs)  wFull_q  <= 1'b1;
      if (commit) begin
        bValid_q <= 1'b1;
        bResp_q  <= awInRange ? RESP_OKAY : RESP_SLVERR;
      end else if (BREADY) begin
        bValid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (awHs) awAddr_q <= AWADDR;
    if (wHs) begin
      wData_q <= WDATA;
      wStrb_q <= WSTRB;
    end
  end

  always_ff @(posedge CLK) begin
    if (commit && awInRange) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wStrb_q[b]) mem_q[awIdx][8*b +: 8] <= wData_q[8*b +: 8];
      end
    end
  end

  // Memory is sampled at the AR edge, so a same-edge commit is not yet visible.
  always_ff @(posedge CLK) begin
    pipeData_q[0] <= arInRange ? mem_q[arIdx] : '0;
    pipeResp_q[0] <= arInRange ? RESP_OKAY : RESP_SLVERR;
    for (int i = 1; i < C_READ_LATENCY; i++) begin
      pipeData_q[i] <= pipeData_q[i-1];
      pipeResp_q[i] <= pipeResp_q[i-1];
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      fifoData_q[wrIdx_q] <= pipeData_q[C_READ_LATENCY-1];
      fifoResp_q[wrIdx_q] <= pipeResp_q[C_READ_LATENCY-1];
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pipeValid_q <= '0;
      wrIdx_q     <= '0;
      rdIdx_q     <= '0;
      count_q     <= '0;
      credit_q    <= '0;
    end else begin
      pipeValid_q[0] <= arHs;
      for (int i = 1; i < C_READ_LATENCY; i++) pipeValid_q[i] <= pipeValid_q[i-1];
      if (push) wrIdx_q <= nextIdx(wrIdx_q);
      if (rHs)  rdIdx_q <= nextIdx(rdIdx_q);
      if (push && !rHs)      count_q <= count_q + CNT_W'(1);
      else if (!push && rHs) count_q <= count_q - CNT_W'(1);
      // Credit covers both pipeline and FIFO occupancy, so the FIFO cannot overflow.
      if (arHs && !rHs)      credit_q <= credit_q + CNT_W'(1);
      else if (!arHs && rHs) credit_q <= credit_q - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_testdrive_axi4_lite_slave_mem.sv
// Directed bench for the AXI4-Lite slave memory: writes, strobes, range errors,
// read ordering, outstanding reads, B backpressure and reset during reads.
module tb_testdrive_axi4_lite_slave_mem;

  localparam int L = 2;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic        CLK, nRST;
  logic [19:0] AWADDR, ARADDR;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic [31:0] WDATA, RDATA;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;
  logic        ARVALID, ARREADY, RVALID, RREADY;

  int checkCount = 0;
  int passCount  = 0;

  testdrive_axi4_lite_slave_mem #(
    .C_ADDR_WIDTH(20), .C_DATA_WIDTH(32), .C_BASE_ADDR(64'h0),
    .C_MEM_DEPTH_LOG2(10), .C_READ_LATENCY(L), .C_OUTSTANDING(4)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic applyStimulus(input logic awv, input logic [19:0] awa, input logic wv,
                               input logic [31:0] wd, input logic [3:0] ws);
    AWVALID = awv; AWADDR = awa; WVALID = wv; WDATA = wd; WSTRB = ws;
  endtask

  task automatic doWrite(input string tag, input logic [19:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input logic [1:0] expResp);
    BREADY = 1'b0;
    applyStimulus(1'b1, addr, 1'b1, data, strb);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    checkOutput({tag, "_bv_early"}, BVALID, 1'b0);
    tick();
    checkOutput({tag, "_bvalid"}, BVALID, 1'b1);
    checkOutput({tag, "_bresp"}, BRESP, expResp);
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    checkOutput({tag, "_bdone"}, BVALID, 1'b0);
  endtask

  task automatic doRead(input string tag, input logic [19:0] addr, input logic [31:0] expData,
                        input logic [1:0] expResp);
    checkOutput({tag, "_arready"}, ARREADY, 1'b1);
    ARVALID = 1'b1; ARADDR = addr;
    tick();
    ARVALID = 1'b0;
    for (int k = 0; k < L; k++) begin
      checkOutput({tag, "_early"}, RVALID, 1'b0);
      tick();
    end
    checkOutput({tag, "_rvalid"}, RVALID, 1'b1);
    checkOutput({tag, "_rdata"}, RDATA, expData);
    checkOutput({tag, "_rresp"}, RRESP, expResp);
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    checkOutput({tag, "_rdone"}, RVALID, 1'b0);
  endtask

  task automatic waitR(input string tag, input logic [31:0] expData, input logic [1:0] expResp);
    int n = 0;
    while (RVALID !== 1'b1 && n < 20) begin tick(); n++; end
    checkOutput({tag, "_rvalid"}, RVALID, 1'b1);
    if (RVALID === 1'b1) begin
      checkOutput({tag, "_rdata"}, RDATA, expData);
      checkOutput({tag, "_rresp"}, RRESP, expResp);
      RREADY = 1'b1;
      tick();
      RREADY = 1'b0;
    end
  endtask

  logic [19:0] oAddr [6];
  logic [31:0] oData [6];
  logic [1:0]  oResp [6];
  int          expQ [$];

  initial begin
    int idx, issued, n;
    logic accepted;
    oAddr = '{20'h10, 20'hFFC, 20'h1000, 20'h20, 20'h13, 20'h1004};
    oData = '{32'hA5FF12FF, 32'h12345678, 32'h0, 32'h22222222, 32'hA5FF12FF, 32'h0};
    oResp = '{OKAY, OKAY, SLVERR, OKAY, OKAY, SLVERR};

    nRST = 1'b0; BREADY = 1'b0; ARVALID = 1'b0; ARADDR = '0; RREADY = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    repeat (2) tick();
    checkOutput("rst_awready", AWREADY, 1'b0);
    checkOutput("rst_wready", WREADY, 1'b0);
    checkOutput("rst_arready", ARREADY, 1'b0);
    checkOutput("rst_bvalid", BVALID, 1'b0);
    checkOutput("rst_rvalid", RVALID, 1'b0);
    nRST = 1'b1;
    #1 checkOutput("rel_awready_before_edge", AWREADY, 1'b0);
    tick();
    checkOutput("rel_awready", AWREADY, 1'b1);
    checkOutput("rel_wready", WREADY, 1'b1);
    checkOutput("rel_arready", ARREADY, 1'b1);

    // Same-cycle AW and W, then read back with exact latency
    doWrite("wr_full", 20'h10, 32'hA5A51234, 4'hF, OKAY);
    doRead("rd_full", 20'h10, 32'hA5A51234, OKAY);

    // W arrives three cycles before AW, with a partial strobe
    applyStimulus(1'b0, '0, 1'b1, 32'hFFFFFFFF, 4'b0101);
    checkOutput("wfirst_wready", WREADY, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    checkOutput("wfirst_wready_held", WREADY, 1'b0);
    tick();
    checkOutput("wfirst_no_b", BVALID, 1'b0);
    tick();
    applyStimulus(1'b1, 20'h10, 1'b0, '0, '0);
    tick();
    AWVALID = 1'b0;
    checkOutput("wfirst_bv_early", BVALID, 1'b0);
    tick();
    checkOutput("wfirst_bvalid", BVALID, 1'b1);
    checkOutput("wfirst_bresp", BRESP, OKAY);
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    doRead("rd_strb", 20'h10, 32'hA5FF12FF, OKAY);
    doRead("rd_unaligned", 20'h13, 32'hA5FF12FF, OKAY);

    // Range boundary and zero-strobe write
    doWrite("wr_last", 20'hFFC, 32'h12345678, 4'hF, OKAY);
    doWrite("wr_oor", 20'h1000, 32'hDEADBEEF, 4'hF, SLVERR);
    doRead("rd_oor", 20'h1000, 32'h0, SLVERR);
    doRead("rd_last", 20'hFFC, 32'h12345678, OKAY);
    doWrite("wr_nostrb", 20'h10, 32'h0, 4'h0, OKAY);
    doRead("rd_nostrb", 20'h10, 32'hA5FF12FF, OKAY);

    // Read accepted on the commit edge sees old data; later read sees new
    doWrite("wr_ord", 20'h20, 32'h11111111, 4'hF, OKAY);
    applyStimulus(1'b1, 20'h20, 1'b1, 32'h22222222, 4'hF);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    ARVALID = 1'b1; ARADDR = 20'h20;
    checkOutput("ord_arready", ARREADY, 1'b1);
    tick();
    ARVALID = 1'b0;
    checkOutput("ord_bvalid", BVALID, 1'b1);
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    waitR("ord_old", 32'h11111111, OKAY);
    doRead("ord_new", 20'h20, 32'h22222222, OKAY);

    // Six back-to-back reads with RREADY low; credit limits acceptance to four
    RREADY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("os_arready%0d", i), ARREADY, 1'b1);
      ARVALID = 1'b1; ARADDR = oAddr[i];
      expQ.push_back(i);
      tick();
    end
    ARADDR = oAddr[4];
    for (int i = 0; i < 3; i++) begin
      checkOutput("os_arready_full", ARREADY, 1'b0);
      tick();
    end
    checkOutput("os_rvalid", RVALID, 1'b1);
    RREADY = 1'b1;
    idx = expQ.pop_front();
    checkOutput("os_rdata0", RDATA, oData[idx]);
    checkOutput("os_rresp0", RRESP, oResp[idx]);
    tick();
    checkOutput("os_arready_reassert", ARREADY, 1'b1);
    issued = 4;
    n = 0;
    while ((issued < 6 || expQ.size() > 0) && n < 50) begin
      if (RVALID === 1'b1) begin
        if (expQ.size() == 0) checkOutput("os_extra_r", RVALID, 1'b0);
        else begin
          idx = expQ.pop_front();
          checkOutput($sformatf("os_rdata%0d", idx), RDATA, oData[idx]);
          checkOutput($sformatf("os_rresp%0d", idx), RRESP, oResp[idx]);
        end
      end
      accepted = ARVALID && ARREADY;
      if (accepted) expQ.push_back(issued);
      tick();
      n++;
      if (accepted) begin
        issued++;
        if (issued < 6) ARADDR = oAddr[issued];
        else ARVALID = 1'b0;
      end
    end
    checkOutput("os_issued", issued, 6);
    checkOutput("os_all_returned", expQ.size(), 0);
    checkOutput("os_rvalid_end", RVALID, 1'b0);
    RREADY = 1'b0;
    ARVALID = 1'b0;

    // B backpressure: second write waits behind a held response
    applyStimulus(1'b1, 20'h30, 1'b1, 32'h30303030, 4'hF);
    tick();
    applyStimulus(1'b1, 20'h2000, 1'b1, 32'hDEADBEEF, 4'hF);
    checkOutput("bp_awready_commit", AWREADY, 1'b0);
    checkOutput("bp_wready_commit", WREADY, 1'b0);
    tick();
    checkOutput("bp_bvalid1", BVALID, 1'b1);
    checkOutput("bp_awready_open", AWREADY, 1'b1);
    checkOutput("bp_wready_open", WREADY, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp_bvalid_held", BVALID, 1'b1);
      checkOutput("bp_bresp_held", BRESP, OKAY);
      checkOutput("bp_awready_stall", AWREADY, 1'b0);
      checkOutput("bp_wready_stall", WREADY, 1'b0);
      tick();
    end
    BREADY = 1'b1;
    tick();
    checkOutput("bp_no_gap", BVALID, 1'b1);
    checkOutput("bp_bresp2", BRESP, SLVERR);
    checkOutput("bp_awready_after", AWREADY, 1'b1);
    tick();
    BREADY = 1'b0;
    checkOutput("bp_bdone", BVALID, 1'b0);
    doRead("bp_rd", 20'h30, 32'h30303030, OKAY);

    // Reset with three reads in flight
    for (int i = 0; i < 3; i++) begin
      ARVALID = 1'b1; ARADDR = 20'h10 + 20'(i * 16);
      tick();
    end
    ARVALID = 1'b0;
    checkOutput("mid_rvalid_before", RVALID, 1'b1);
    nRST = 1'b0;
    #1;
    checkOutput("mid_rst_awready", AWREADY, 1'b0);
    checkOutput("mid_rst_wready", WREADY, 1'b0);
    checkOutput("mid_rst_arready", ARREADY, 1'b0);
    checkOutput("mid_rst_bvalid", BVALID, 1'b0);
    checkOutput("mid_rst_bresp", BRESP, 2'b00);
    checkOutput("mid_rst_rvalid", RVALID, 1'b0);
    checkOutput("mid_rst_rdata", RDATA, 32'h0);
    checkOutput("mid_rst_rresp", RRESP, 2'b00);
    repeat (2) tick();
    nRST = 1'b1;
    #1 checkOutput("mid_rel_arready_early", ARREADY, 1'b0);
    tick();
    checkOutput("mid_rel_arready", ARREADY, 1'b1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("mid_no_rvalid", RVALID, 1'b0);
      tick();
    end
    doRead("mid_retained", 20'h30, 32'h30303030, OKAY);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
